// File: rtl/game_flow_ctrl_n_if.sv
// Game-flow handshake bundle between the flow controller and the game datapath.
// The datapath/VGA side (master) drives the done/event strobes and consumes the
// phase enables; the controller (slave) does the reverse.
// pause_req/paused are only meaningful when PAUSE_FLOW_EN is defined.
interface game_flow_ctrl_n_if #(
   parameter int STAGE_W = 4,
   parameter int LIFE_W  = 4
);
   logic               start_display_done;
   logic               begin_done;
   logic               tower_done;
   logic               stage_clear;
   logic               player_dead;
   logic               end_display_done;
   logic               fail_display_done;
   logic               pause_req;

   logic               wait_start;
   logic               phase_begin;
   logic               phase_draw_tower;
   logic               phase_in_progress;
   logic               phase_stage_done;
   logic               phase_fail;
   logic               paused;
   logic               stage_start;
   logic [STAGE_W-1:0] stage_idx;
   logic [LIFE_W-1:0]  lives_left;
   logic               win;
   logic               game_over;

   modport master (
      output start_display_done, begin_done, tower_done, stage_clear,
             player_dead, end_display_done, fail_display_done, pause_req,
      input  wait_start, phase_begin, phase_draw_tower, phase_in_progress,
             phase_stage_done, phase_fail, paused, stage_start, stage_idx,
             lives_left, win, game_over
   );

   modport slave (
      input  start_display_done, begin_done, tower_done, stage_clear,
             player_dead, end_display_done, fail_display_done, pause_req,
      output wait_start, phase_begin, phase_draw_tower, phase_in_progress,
             phase_stage_done, phase_fail, paused, stage_start, stage_idx,
             lives_left, win, game_over
   );
endinterface

// File: rtl/game_flow_ctrl_n.sv
// Top-level game-flow controller: start screen, then NUM_STAGES stages of
// begin / draw tower / in progress / clear display, with NUM_LIVES attempts.
// A failed stage shows the fail screen and replays the same stage.
// All outputs are registered and decoded from the next state.
// Optional macro PAUSE_FLOW_EN: pause_req rising edges toggle a freeze of the
// in-progress phase; without it pause_req is unused and paused is 0.
module game_flow_ctrl_n #(
   parameter int NUM_STAGES = 3,
   parameter int NUM_LIVES  = 1,
   parameter int STAGE_W    = 4,
   parameter int LIFE_W     = 4
) (
   input logic                clk,
   input logic                reset,
   game_flow_ctrl_n_if.slave  flow
);

   typedef enum logic [3:0] {
      S_RESET       = 4'd0,
      S_WAIT_START  = 4'd1,
      S_BEGIN       = 4'd2,
      S_DRAW_TOWER  = 4'd3,
      S_IN_PROGRESS = 4'd4,
      S_STAGE_DONE  = 4'd5,
      S_FAIL        = 4'd6,
      S_WIN         = 4'd7,
      S_GAME_OVER   = 4'd8
   } state_t;

   localparam logic [STAGE_W-1:0] LAST_STAGE = STAGE_W'(NUM_STAGES - 1);
   localparam logic [LIFE_W-1:0]  INIT_LIVES = LIFE_W'(NUM_LIVES);

   state_t             state_q, state_d;
   logic [STAGE_W-1:0] stage_q, stage_d;
   logic [LIFE_W-1:0]  lives_q, lives_d;

   logic wait_start_q, begin_q, draw_tower_q, in_progress_q;
   logic stage_done_q, fail_q, win_q, game_over_q, stage_start_q;
   logic paused_q;

`ifdef PAUSE_FLOW_EN
   logic pause_req_q;
   logic pause_rise;
   logic paused_d;

   assign pause_rise = flow.pause_req & ~pause_req_q;

   // Pause toggles only while staying in IN_PROGRESS; any exit clears it.
   always_comb begin
      paused_d = 1'b0;
      if (state_q == S_IN_PROGRESS && state_d == S_IN_PROGRESS)
         paused_d = paused_q ^ pause_rise;
   end

   // Edge-detect history for pause_req plus the pause flag itself.
   always_ff @(posedge clk) begin
      pause_req_q <= flow.pause_req;
      if (reset) paused_q <= 1'b0;
      else       paused_q <= paused_d;
   end
`else
   assign paused_q = 1'b0;
`endif

   // Next-state, stage and lives update; each state looks only at its own done input.
   always_comb begin
      state_d = state_q;
      stage_d = stage_q;
      lives_d = lives_q;
      case (state_q)
         S_RESET:       state_d = S_WAIT_START;
         S_WAIT_START:  if (flow.start_display_done) state_d = S_BEGIN;
         S_BEGIN:       if (flow.begin_done)         state_d = S_DRAW_TOWER;
         S_DRAW_TOWER:  if (flow.tower_done)         state_d = S_IN_PROGRESS;
         S_IN_PROGRESS: begin
            if (!paused_q) begin
               if (flow.stage_clear) begin
                  state_d = S_STAGE_DONE;
               end else if (flow.player_dead) begin
                  state_d = S_FAIL;
                  lives_d = (lives_q != '0) ? lives_q - LIFE_W'(1) : '0;
               end
            end
         end
         S_STAGE_DONE: begin
            if (flow.end_display_done) begin
               if (stage_q >= LAST_STAGE) begin
                  state_d = S_WIN;
               end else begin
                  stage_d = stage_q + STAGE_W'(1);
                  state_d = S_BEGIN;
               end
            end
         end
         S_FAIL: begin
            // Lives were already decremented on entry; zero means no retry left.
            if (lives_q == '0)               state_d = S_GAME_OVER;
            else if (flow.fail_display_done) state_d = S_BEGIN;
         end
         S_WIN:       state_d = S_WIN;
         S_GAME_OVER: state_d = S_GAME_OVER;
         default:     state_d = S_RESET;
      endcase
   end

   // State, counters and registered one-hot phase outputs.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q       <= S_RESET;
         stage_q       <= '0;
         lives_q       <= INIT_LIVES;
         wait_start_q  <= 1'b0;
         begin_q       <= 1'b0;
         draw_tower_q  <= 1'b0;
         in_progress_q <= 1'b0;
         stage_done_q  <= 1'b0;
         fail_q        <= 1'b0;
         win_q         <= 1'b0;
         game_over_q   <= 1'b0;
         stage_start_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         stage_q       <= stage_d;
         lives_q       <= lives_d;
         wait_start_q  <= (state_d == S_WAIT_START);
         begin_q       <= (state_d == S_BEGIN);
         draw_tower_q  <= (state_d == S_DRAW_TOWER);
         in_progress_q <= (state_d == S_IN_PROGRESS);
         stage_done_q  <= (state_d == S_STAGE_DONE);
         fail_q        <= (state_d == S_FAIL);
         win_q         <= (state_d == S_WIN);
         game_over_q   <= (state_d == S_GAME_OVER);
         stage_start_q <= (state_d == S_BEGIN) && (state_q != S_BEGIN);
      end
   end

   assign flow.wait_start        = wait_start_q;
   assign flow.phase_begin       = begin_q;
   assign flow.phase_draw_tower  = draw_tower_q;
   assign flow.phase_in_progress = in_progress_q;
   assign flow.phase_stage_done  = stage_done_q;
   assign flow.phase_fail        = fail_q;
   assign flow.paused            = paused_q;
   assign flow.stage_start       = stage_start_q;
   assign flow.stage_idx         = stage_q;
   assign flow.lives_left        = lives_q;
   assign flow.win               = win_q;
   assign flow.game_over         = game_over_q;

endmodule

// File: tb/tb_game_flow_ctrl_n.sv
// Self-checking bench for game_flow_ctrl_n (NUM_STAGES=3, NUM_LIVES=2).
// Directed table, hand sequences for retry/priority/held-done/reset corners,
// then randomized stimulus against a phase-level reference model.
module tb_game_flow_ctrl_n;
   localparam int NS = 3;
   localparam int NL = 2;
   localparam int SW = 4;
   localparam int LW = 4;

   // Expected phase codes: {wait_start, begin, draw_tower, in_progress, stage_done, fail, win, game_over}
   localparam logic [7:0] O_RS = 8'h00, O_WS = 8'h80, O_BG = 8'h40, O_DT = 8'h20,
                          O_IP = 8'h10, O_SD = 8'h08, O_FL = 8'h04, O_WN = 8'h02,
                          O_GO = 8'h01;
   // Input strobes: {start_display, begin, tower, stage_clear, player_dead, end_display, fail_display}
   localparam logic [6:0] I_0 = 7'h00, I_SDD = 7'h40, I_BD = 7'h20, I_TD = 7'h10,
                          I_SC = 7'h08, I_PD = 7'h04, I_EDD = 7'h02, I_FDD = 7'h01;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   game_flow_ctrl_n_if #(.STAGE_W(SW), .LIFE_W(LW)) flow ();

   game_flow_ctrl_n #(.NUM_STAGES(NS), .NUM_LIVES(NL), .STAGE_W(SW), .LIFE_W(LW)) dut (
      .clk   (clk),
      .reset (reset),
      .flow  (flow)
   );

   int checks = 0;
   int failures = 0;

   // Reference model: the phase is held as the expected output pattern.
   logic [7:0] m_ph = O_RS;
   int         m_stage = 0;
   int         m_lives = NL;
   bit         m_paused = 1'b0;
   bit         m_prevp = 1'b0;
   bit         m_ss = 1'b0;

   typedef struct {
      logic       r;
      logic [6:0] d;
      logic [7:0] oh;
      logic       ss;
      int         idx;
      int         lv;
   } vec_t;
   vec_t tbl[18];

   function automatic logic [7:0] dut_oh();
      return {flow.wait_start, flow.phase_begin, flow.phase_draw_tower, flow.phase_in_progress,
              flow.phase_stage_done, flow.phase_fail, flow.win, flow.game_over};
   endfunction

   task automatic check(input string nm, input logic [7:0] eoh, input logic ess,
                        input int eidx, input int elv, input logic ep);
      checks++;
      if (dut_oh() !== eoh || flow.stage_start !== ess || flow.stage_idx !== SW'(eidx) ||
          flow.lives_left !== LW'(elv) || flow.paused !== ep) begin
         failures++;
         $display("FAIL %s: got oh=%b ss=%b idx=%0d lives=%0d paused=%b, want oh=%b ss=%b idx=%0d lives=%0d paused=%b",
                  nm, dut_oh(), flow.stage_start, flow.stage_idx, flow.lives_left, flow.paused,
                  eoh, ess, eidx, elv, ep);
      end
   endtask

   task automatic model_step(input logic r, input logic [6:0] d, input logic p);
      logic [7:0] nx;
      bit rise;
      nx = m_ph;
`ifdef PAUSE_FLOW_EN
      rise = p && !m_prevp;
`else
      rise = 1'b0;
`endif
      if (r) begin
         nx = O_RS; m_stage = 0; m_lives = NL; m_paused = 1'b0;
      end else begin
         case (m_ph)
            O_RS: nx = O_WS;
            O_WS: if (d[6]) nx = O_BG;
            O_BG: if (d[5]) nx = O_DT;
            O_DT: if (d[4]) nx = O_IP;
            O_IP: begin
               if (!m_paused && d[3]) nx = O_SD;
               else if (!m_paused && d[2]) begin
                  nx = O_FL;
                  m_lives = (m_lives > 0) ? m_lives - 1 : 0;
               end else if (rise) m_paused = !m_paused;
            end
            O_SD: if (d[1]) begin
               if (m_stage == NS - 1) nx = O_WN;
               else begin m_stage++; nx = O_BG; end
            end
            O_FL: begin
               if (m_lives == 0) nx = O_GO;
               else if (d[0]) nx = O_BG;
            end
            default: ;
         endcase
      end
      if (nx != O_IP) m_paused = 1'b0;
      m_ss = !r && (nx == O_BG) && (m_ph != O_BG);
      m_ph = nx;
      m_prevp = p;
   endtask

   // One clock: drive on the falling edge, advance the model on the rising edge, compare 1 ns later.
   task automatic step(input logic r, input logic [6:0] d, input logic p, input string nm);
      @(negedge clk);
      reset = r;
      {flow.start_display_done, flow.begin_done, flow.tower_done, flow.stage_clear,
       flow.player_dead, flow.end_display_done, flow.fail_display_done} = d;
      flow.pause_req = p;
      @(posedge clk);
      model_step(r, d, p);
      #1;
      check({"model_", nm}, m_ph, m_ss, m_stage, m_lives, m_paused);
   endtask

   // Reset, leave the start screen, clear k stages, then stop in IN_PROGRESS of stage k.
   task automatic to_in_progress(input int k);
      step(1'b1, I_0, 1'b0, "rst");
      step(1'b0, I_0, 1'b0, "ws");
      step(1'b0, I_SDD, 1'b0, "sdd");
      for (int i = 0; i < k; i++) begin
         step(1'b0, I_BD, 1'b0, "bd");
         step(1'b0, I_TD, 1'b0, "td");
         step(1'b0, I_SC, 1'b0, "sc");
         step(1'b0, I_EDD, 1'b0, "edd");
      end
      step(1'b0, I_BD, 1'b0, "bd");
      step(1'b0, I_TD, 1'b0, "td");
   endtask

   initial begin
      int ss_cnt;
      logic p;
      {flow.start_display_done, flow.begin_done, flow.tower_done, flow.stage_clear,
       flow.player_dead, flow.end_display_done, flow.fail_display_done} = '0;
      flow.pause_req = 1'b0;

      tbl[0]  = '{1'b1, I_0,         O_RS, 1'b0, 0, NL};
      tbl[1]  = '{1'b1, I_0,         O_RS, 1'b0, 0, NL};
      tbl[2]  = '{1'b0, I_0,         O_WS, 1'b0, 0, NL};
      tbl[3]  = '{1'b0, I_SDD,       O_BG, 1'b1, 0, NL};
      tbl[4]  = '{1'b0, I_0,         O_BG, 1'b0, 0, NL};
      tbl[5]  = '{1'b0, I_BD,        O_DT, 1'b0, 0, NL};
      tbl[6]  = '{1'b0, I_TD,        O_IP, 1'b0, 0, NL};
      tbl[7]  = '{1'b0, I_SC,        O_SD, 1'b0, 0, NL};
      tbl[8]  = '{1'b0, I_EDD,       O_BG, 1'b1, 1, NL};
      tbl[9]  = '{1'b0, I_BD,        O_DT, 1'b0, 1, NL};
      tbl[10] = '{1'b0, I_TD,        O_IP, 1'b0, 1, NL};
      tbl[11] = '{1'b0, I_SC,        O_SD, 1'b0, 1, NL};
      tbl[12] = '{1'b0, I_EDD,       O_BG, 1'b1, 2, NL};
      tbl[13] = '{1'b0, I_BD,        O_DT, 1'b0, 2, NL};
      tbl[14] = '{1'b0, I_TD,        O_IP, 1'b0, 2, NL};
      tbl[15] = '{1'b0, I_SC,        O_SD, 1'b0, 2, NL};
      tbl[16] = '{1'b0, I_EDD,       O_WN, 1'b0, 2, NL};
      tbl[17] = '{1'b0, I_SDD | I_BD, O_WN, 1'b0, 2, NL};

      // Full three-stage win
      ss_cnt = 0;
      for (int i = 0; i < 18; i++) begin
         step(tbl[i].r, tbl[i].d, 1'b0, $sformatf("tbl%0d", i));
         check($sformatf("tbl%0d", i), tbl[i].oh, tbl[i].ss, tbl[i].idx, tbl[i].lv, 1'b0);
         if (flow.stage_start === 1'b1) ss_cnt++;
      end
      checks++;
      if (ss_cnt != 3) begin
         failures++;
         $display("FAIL stage_start_count: got %0d want 3", ss_cnt);
      end

      // Death in stage 1, retry, second death -> game over
      to_in_progress(1);
      check("ip_idx1", O_IP, 1'b0, 1, 2, 1'b0);
      step(1'b0, I_PD, 1'b0, "pd1");
      check("fail_entry", O_FL, 1'b0, 1, 1, 1'b0);
      step(1'b0, I_0, 1'b0, "fail_hold");
      check("fail_hold", O_FL, 1'b0, 1, 1, 1'b0);
      step(1'b0, I_FDD, 1'b0, "retry");
      check("retry_begin", O_BG, 1'b1, 1, 1, 1'b0);
      step(1'b0, I_BD, 1'b0, "bd");
      step(1'b0, I_TD, 1'b0, "td");
      step(1'b0, I_PD, 1'b0, "pd2");
      check("fail_last", O_FL, 1'b0, 1, 0, 1'b0);
      step(1'b0, I_0, 1'b0, "go");
      check("game_over", O_GO, 1'b0, 1, 0, 1'b0);
      step(1'b0, I_FDD | I_SDD, 1'b0, "go_hold");
      check("game_over_hold", O_GO, 1'b0, 1, 0, 1'b0);

      // stage_clear beats player_dead
      to_in_progress(0);
      step(1'b0, I_SC | I_PD, 1'b0, "both");
      check("clear_wins", O_SD, 1'b0, 0, 2, 1'b0);

      // tower_done held from BEGIN onward
      step(1'b1, I_0, 1'b0, "rst");
      step(1'b0, I_0, 1'b0, "ws");
      step(1'b0, I_SDD | I_TD, 1'b0, "sdd_td");
      check("held_begin0", O_BG, 1'b1, 0, 2, 1'b0);
      step(1'b0, I_TD, 1'b0, "td_in_begin");
      check("held_begin1", O_BG, 1'b0, 0, 2, 1'b0);
      step(1'b0, I_BD | I_TD, 1'b0, "bd_td");
      check("held_draw", O_DT, 1'b0, 0, 2, 1'b0);
      step(1'b0, I_TD, 1'b0, "td_draw");
      check("held_ip", O_IP, 1'b0, 0, 2, 1'b0);

      // Reset in the middle of stage index 1
      to_in_progress(1);
      step(1'b1, I_0, 1'b0, "mid_rst");
      check("mid_reset", O_RS, 1'b0, 0, NL, 1'b0);
      step(1'b0, I_0, 1'b0, "after_rst");
      check("after_reset", O_WS, 1'b0, 0, NL, 1'b0);

`ifdef PAUSE_FLOW_EN
      to_in_progress(0);
      step(1'b0, I_0, 1'b1, "p_edge1");
      check("pause_on", O_IP, 1'b0, 0, 2, 1'b1);
      step(1'b0, I_SC, 1'b1, "p_sc");
      check("pause_ignore_clear", O_IP, 1'b0, 0, 2, 1'b1);
      step(1'b0, I_PD, 1'b0, "p_pd");
      check("pause_ignore_dead", O_IP, 1'b0, 0, 2, 1'b1);
      step(1'b0, I_0, 1'b1, "p_edge2");
      check("pause_off", O_IP, 1'b0, 0, 2, 1'b0);
      step(1'b0, I_SC, 1'b0, "p_clear");
      check("resume_clear", O_SD, 1'b0, 0, 2, 1'b0);
`endif

      // Randomized run against the model
      step(1'b1, I_0, 1'b0, "rnd_rst");
      p = 1'b0;
      for (int i = 0; i < 3000; i++) begin
         logic r;
         logic [6:0] d;
         r = ($urandom_range(0, 299) == 0);
         d = 7'($urandom) & 7'($urandom);
         if ($urandom_range(0, 5) == 0) p = ~p;
         step(r, d, p, "rnd");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
